// File: rtl/mor1kx_dpram_ctrl.sv
// Front end for a single-clock true dual-port RAM: two requesters with round-robin
// resolution of same-address conflicts, plus a clear sweep after reset or on request.
module mor1kx_dpram_ctrl #(
  parameter int unsigned            ADDR_WIDTH  = 5,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  output logic                  busy_o,
  input  logic                  req_a_i,
  input  logic                  req_b_i,
  input  logic                  we_a_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] wdat_a_i,
  input  logic [DATA_WIDTH-1:0] wdat_b_i,
  output logic                  ack_a_o,
  output logic                  ack_b_o,
  output logic                  rvalid_a_o,
  output logic                  rvalid_b_o,
  output logic [DATA_WIDTH-1:0] rdat_a_o,
  output logic [DATA_WIDTH-1:0] rdat_b_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_a_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_b_o,
  output logic                  ram_we_a_o,
  output logic                  ram_we_b_o,
  output logic [DATA_WIDTH-1:0] ram_din_a_o,
  output logic [DATA_WIDTH-1:0] ram_din_b_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_a_i,
  input  logic [DATA_WIDTH-1:0] ram_dout_b_i
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  // Last even address of the sweep (2^ADDR_WIDTH - 2); port B covers the odd partner.
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ~ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_STEP = ADDR_WIDTH'(2);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  prio_b_q, prio_b_d;
  logic                  rvalid_a_q, rvalid_b_q;
  logic                  run;
  logic                  conflict;

  assign run      = (state_q == RUN) && !clear_i;
  assign conflict = req_a_i && req_b_i && (addr_a_i == addr_b_i) && (we_a_i || we_b_i);

  // On a conflict only the prioritised side is granted; the other simply retries.
  assign ack_a_o = run && req_a_i && !(conflict && prio_b_q);
  assign ack_b_o = run && req_b_i && !(conflict && !prio_b_q);

  assign busy_o     = (state_q == CLEAR);
  assign rvalid_a_o = rvalid_a_q;
  assign rvalid_b_o = rvalid_b_q;
  assign rdat_a_o   = ram_dout_a_i;
  assign rdat_b_o   = ram_dout_b_i;

  always_comb begin
    ram_addr_a_o = addr_a_i;
    ram_addr_b_o = addr_b_i;
    ram_we_a_o   = ack_a_o && we_a_i;
    ram_we_b_o   = ack_b_o && we_b_i;
    ram_din_a_o  = wdat_a_i;
    ram_din_b_o  = wdat_b_i;
    if (state_q == CLEAR) begin
      ram_addr_a_o = cnt_q;
      ram_addr_b_o = cnt_q | ADDR_WIDTH'(1);
      ram_we_a_o   = 1'b1;
      ram_we_b_o   = 1'b1;
      ram_din_a_o  = CLEAR_VALUE;
      ram_din_b_o  = CLEAR_VALUE;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    prio_b_d = prio_b_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + CNT_STEP;
      if (cnt_q == CNT_LAST) begin
        state_d = RUN;
      end
    end else if (clear_i) begin
      state_d = CLEAR;
    end
    // Loser of this conflict wins the next one.
    if (run && conflict) begin
      prio_b_d = !prio_b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      prio_b_q   <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prio_b_q   <= prio_b_d;
      rvalid_a_q <= ack_a_o && !we_a_i;
      rvalid_b_q <= ack_b_o && !we_b_i;
    end
  end

endmodule

// File: tb/tb_mor1kx_dpram_ctrl.sv
// Directed bench for mor1kx_dpram_ctrl with a behavioural dual-port RAM attached.
module tb_mor1kx_dpram_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] CV = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_i;
  logic          busy_o;
  logic          req_a_i, req_b_i, we_a_i, we_b_i;
  logic [AW-1:0] addr_a_i, addr_b_i;
  logic [DW-1:0] wdat_a_i, wdat_b_i;
  logic          ack_a_o, ack_b_o, rvalid_a_o, rvalid_b_o;
  logic [DW-1:0] rdat_a_o, rdat_b_o;
  logic [AW-1:0] ram_addr_a_o, ram_addr_b_o;
  logic          ram_we_a_o, ram_we_b_o;
  logic [DW-1:0] ram_din_a_o, ram_din_b_o;
  logic [DW-1:0] ram_dout_a_i, ram_dout_b_i;

  int n_checks = 0;
  int n_pass   = 0;

  mor1kx_dpram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CLEAR_VALUE(CV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_i),
    .busy_o      (busy_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .we_a_i      (we_a_i),
    .we_b_i      (we_b_i),
    .addr_a_i    (addr_a_i),
    .addr_b_i    (addr_b_i),
    .wdat_a_i    (wdat_a_i),
    .wdat_b_i    (wdat_b_i),
    .ack_a_o     (ack_a_o),
    .ack_b_o     (ack_b_o),
    .rvalid_a_o  (rvalid_a_o),
    .rvalid_b_o  (rvalid_b_o),
    .rdat_a_o    (rdat_a_o),
    .rdat_b_o    (rdat_b_o),
    .ram_addr_a_o(ram_addr_a_o),
    .ram_addr_b_o(ram_addr_b_o),
    .ram_we_a_o  (ram_we_a_o),
    .ram_we_b_o  (ram_we_b_o),
    .ram_din_a_o (ram_din_a_o),
    .ram_din_b_o (ram_din_b_o),
    .ram_dout_a_i(ram_dout_a_i),
    .ram_dout_b_i(ram_dout_b_i)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, write-through on the writing port, read-first across ports.
  logic [DW-1:0] mem [16];
  int            wr_cnt [16];

  always @(posedge clk) begin
    if (ram_we_a_o) mem[ram_addr_a_o] <= ram_din_a_o;
    if (ram_we_b_o) mem[ram_addr_b_o] <= ram_din_b_o;
    ram_dout_a_i <= ram_we_a_o ? ram_din_a_o : mem[ram_addr_a_o];
    ram_dout_b_i <= ram_we_b_o ? ram_din_b_o : mem[ram_addr_b_o];
    if (rst) begin
      for (int i = 0; i < 16; i++) wr_cnt[i] <= 0;
    end else if (busy_o) begin
      if (ram_we_a_o) wr_cnt[ram_addr_a_o] <= wr_cnt[ram_addr_a_o] + 1;
      if (ram_we_b_o) wr_cnt[ram_addr_b_o] <= wr_cnt[ram_addr_b_o] + 1;
    end
  end

  task automatic idle();
    req_a_i = 1'b0; req_b_i = 1'b0; we_a_i = 1'b0; we_b_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts before a negedge; returns positioned at the negedge of the first non-busy cycle.
  task automatic count_busy(output int n, output int acks);
    n = 0;
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy_o) break;
      n++;
      if (ack_a_o || ack_b_o) acks++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    req_a_i = 1'b1; addr_a_i = 4'd0;
    req_b_i = 1'b1; addr_b_i = 4'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy_o); else n_pass++;
    n_checks++;
    if ({ack_a_o, ack_b_o} !== 2'b00) $display("FAIL reset_ack: got %b want 00", {ack_a_o, ack_b_o});
    else n_pass++;
    n_checks++;
    if ({rvalid_a_o, rvalid_b_o} !== 2'b00)
      $display("FAIL reset_rvalid: got %b want 00", {rvalid_a_o, rvalid_b_o});
    else n_pass++;
    n_checks++;
    if ({ram_addr_a_o, ram_addr_b_o, ram_we_a_o, ram_we_b_o} !== {4'd0, 4'd1, 2'b11})
      $display("FAIL reset_ramport: got %h want %h",
               {ram_addr_a_o, ram_addr_b_o, ram_we_a_o, ram_we_b_o}, {4'd0, 4'd1, 2'b11});
    else n_pass++;
    n_checks++;
    if (ram_din_a_o !== CV) $display("FAIL reset_din: got %h want %h", ram_din_a_o, CV);
    else n_pass++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    int n, acks, bad;
    count_busy(n, acks);
    n_checks++;
    if (n != 8) $display("FAIL sweep_len: got %0d want 8", n); else n_pass++;
    n_checks++;
    if (acks != 0) $display("FAIL sweep_ack: got %0d want 0", acks); else n_pass++;
    n_checks++;
    if ({ack_a_o, ack_b_o} !== 2'b11)
      $display("FAIL sweep_held_ack: got %b want 11", {ack_a_o, ack_b_o});
    else n_pass++;
    step();
    idle();
    bad = 0;
    for (int i = 0; i < 16; i++) if (wr_cnt[i] != 1) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL sweep_cover: got %0d bad addresses want 0", bad); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      req_a_i = 1'b1; addr_a_i = AW'(2 * i);
      req_b_i = 1'b1; addr_b_i = AW'(2 * i + 1);
      @(negedge clk);
      n_checks++;
      if ({ack_a_o, ack_b_o} !== 2'b11)
        $display("FAIL readall_ack: got %b want 11", {ack_a_o, ack_b_o});
      else n_pass++;
      step();
      idle();
      @(negedge clk);
      n_checks++;
      if ({rvalid_a_o, rvalid_b_o, rdat_a_o, rdat_b_o} !== {2'b11, CV, CV})
        $display("FAIL readall_data: got %b %h %h want 11 %h %h",
                 {rvalid_a_o, rvalid_b_o}, rdat_a_o, rdat_b_o, CV, CV);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_parallel_write();
    req_a_i = 1'b1; we_a_i = 1'b1; addr_a_i = 4'd5; wdat_a_i = 32'h11;
    req_b_i = 1'b1; we_b_i = 1'b1; addr_b_i = 4'd9; wdat_b_i = 32'h22;
    @(negedge clk);
    n_checks++;
    if ({ack_a_o, ack_b_o} !== 2'b11) $display("FAIL pw_ack: got %b want 11", {ack_a_o, ack_b_o});
    else n_pass++;
    step();
    we_a_i = 1'b0; addr_a_i = 4'd9;
    we_b_i = 1'b0; addr_b_i = 4'd5;
    @(negedge clk);
    n_checks++;
    if ({ack_a_o, ack_b_o, rvalid_a_o, rvalid_b_o} !== 4'b1100)
      $display("FAIL pr_ack: got %b want 1100", {ack_a_o, ack_b_o, rvalid_a_o, rvalid_b_o});
    else n_pass++;
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({rvalid_a_o, rvalid_b_o, rdat_a_o, rdat_b_o} !== {2'b11, 32'h22, 32'h11})
      $display("FAIL pr_data: got %b %h %h want 11 22 11",
               {rvalid_a_o, rvalid_b_o}, rdat_a_o, rdat_b_o);
    else n_pass++;
    step();
  endtask

  task automatic test_conflict();
    req_a_i = 1'b1; we_a_i = 1'b1; addr_a_i = 4'd3; wdat_a_i = 32'hAA;
    req_b_i = 1'b1; we_b_i = 1'b0; addr_b_i = 4'd3;
    @(negedge clk);
    n_checks++;
    if ({ack_a_o, ack_b_o, ram_we_b_o} !== 3'b100)
      $display("FAIL cf1_first: got %b want 100", {ack_a_o, ack_b_o, ram_we_b_o});
    else n_pass++;
    step();
    req_a_i = 1'b0; we_a_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack_b_o !== 1'b1) $display("FAIL cf1_second: got %b want 1", ack_b_o); else n_pass++;
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({rvalid_b_o, rdat_b_o} !== {1'b1, 32'hAA})
      $display("FAIL cf1_data: got %b %h want 1 aa", rvalid_b_o, rdat_b_o);
    else n_pass++;
    step();
    req_a_i = 1'b1; we_a_i = 1'b1; addr_a_i = 4'd7; wdat_a_i = 32'h33;
    req_b_i = 1'b1; we_b_i = 1'b1; addr_b_i = 4'd7; wdat_b_i = 32'h44;
    @(negedge clk);
    n_checks++;
    if ({ack_a_o, ack_b_o} !== 2'b01) $display("FAIL cf2_first: got %b want 01", {ack_a_o, ack_b_o});
    else n_pass++;
    step();
    req_b_i = 1'b0; we_b_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack_a_o !== 1'b1) $display("FAIL cf2_second: got %b want 1", ack_a_o); else n_pass++;
    step();
    we_a_i = 1'b0;
    @(negedge clk);
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({rvalid_a_o, rdat_a_o} !== {1'b1, 32'h33})
      $display("FAIL cf2_data: got %b %h want 1 33", rvalid_a_o, rdat_a_o);
    else n_pass++;
    step();
  endtask

  task automatic test_read_read();
    req_a_i = 1'b1; addr_a_i = 4'd2;
    req_b_i = 1'b1; addr_b_i = 4'd2;
    @(negedge clk);
    n_checks++;
    if ({ack_a_o, ack_b_o} !== 2'b11) $display("FAIL rr_ack: got %b want 11", {ack_a_o, ack_b_o});
    else n_pass++;
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({rvalid_a_o, rvalid_b_o, rdat_a_o, rdat_b_o} !== {2'b11, CV, CV})
      $display("FAIL rr_data: got %b %h %h want 11 %h %h",
               {rvalid_a_o, rvalid_b_o}, rdat_a_o, rdat_b_o, CV, CV);
    else n_pass++;
    step();
    // Priority must still favour A after the read/read pair.
    req_a_i = 1'b1; we_a_i = 1'b1; addr_a_i = 4'd4; wdat_a_i = 32'h55;
    req_b_i = 1'b1; we_b_i = 1'b1; addr_b_i = 4'd4; wdat_b_i = 32'h66;
    @(negedge clk);
    n_checks++;
    if ({ack_a_o, ack_b_o} !== 2'b10) $display("FAIL rr_prio: got %b want 10", {ack_a_o, ack_b_o});
    else n_pass++;
    step();
    req_a_i = 1'b0; we_a_i = 1'b0;
    @(negedge clk);
    step();
    we_b_i = 1'b0;
    @(negedge clk);
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({rvalid_b_o, rdat_b_o} !== {1'b1, 32'h66})
      $display("FAIL rr_final: got %b %h want 1 66", rvalid_b_o, rdat_b_o);
    else n_pass++;
    step();
  endtask

  task automatic test_clear();
    int n, acks;
    req_b_i = 1'b1; addr_b_i = 4'd9;
    @(negedge clk);
    step();
    idle();
    clear_i = 1'b1;
    req_a_i = 1'b1; addr_a_i = 4'd5;
    @(negedge clk);
    n_checks++;
    if ({ack_a_o, busy_o} !== 2'b00) $display("FAIL clr_noack: got %b want 00", {ack_a_o, busy_o});
    else n_pass++;
    n_checks++;
    if ({rvalid_b_o, rdat_b_o} !== {1'b1, 32'h22})
      $display("FAIL clr_prev_rvalid: got %b %h want 1 22", rvalid_b_o, rdat_b_o);
    else n_pass++;
    step();
    clear_i = 1'b0;
    count_busy(n, acks);
    n_checks++;
    if (n != 8 || acks != 0) $display("FAIL clr_sweep: got %0d/%0d want 8/0", n, acks);
    else n_pass++;
    n_checks++;
    if (ack_a_o !== 1'b1) $display("FAIL clr_ack_after: got %b want 1", ack_a_o); else n_pass++;
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({rvalid_a_o, rdat_a_o} !== {1'b1, CV})
      $display("FAIL clr_data: got %b %h want 1 %h", rvalid_a_o, rdat_a_o, CV);
    else n_pass++;
    step();
  endtask

  task automatic test_rst_mid_sweep();
    int n, acks;
    bit found;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_o && ram_addr_a_o == 4'd6) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!found) $display("FAIL rstmid_reach: got 0 want 1"); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy_o, ram_addr_a_o, rvalid_a_o, rvalid_b_o} !== {1'b1, 4'd0, 2'b00})
      $display("FAIL rstmid_state: got %b want 1000000",
               {busy_o, ram_addr_a_o, rvalid_a_o, rvalid_b_o});
    else n_pass++;
    step();
    count_busy(n, acks);
    n_checks++;
    if (n != 7) $display("FAIL rstmid_sweep: got %0d want 7 more", n); else n_pass++;
    step();
  endtask

  initial begin
    wdat_a_i = '0; wdat_b_i = '0; addr_a_i = '0; addr_b_i = '0;
    test_reset();
    test_sweep();
    test_parallel_write();
    test_conflict();
    test_read_read();
    test_clear();
    test_rst_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
